// File: rtl/bist_controller.sv
// -----------------------------------------------------------------------------
// bist_controller
//
// Sequences a logic-BIST run over a single scan chain. The run has these steps:
//   1. Seed the LFSR and clear the MISR (INIT).
//   2. Shift N_PATTERNS patterns into the chain, with one functional capture
//      after each pattern (SHIFT and CAPTURE).
//   3. Flush the last captured response into the MISR (FLUSH).
//   4. Compare the signature against GOLDEN_SIG (COMPARE).
//   5. Report the result until the requester drops bist_start (DONE).
//
// Ports
//   clock       : single clock; all state changes on its rising edge
//   reset       : asynchronous, active-low reset
//   bist_start  : run request, sampled only in IDLE and DONE
//   misr_sig    : current MISR signature (MISR_W bits)
//   test_mode   : selects BIST sources over functional inputs (INIT..COMPARE)
//   init        : one-cycle LFSR seed / MISR clear
//   scan_en     : scan-chain shift enable
//   capture     : one-cycle functional capture into the chain
//   lfsr_en     : LFSR advance enable
//   misr_en     : MISR compaction enable
//   busy        : run in progress (INIT..COMPARE)
//   bist_end    : run complete (DONE)
//   pass_nfail  : 1 when the signature matched GOLDEN_SIG; valid in DONE
//
// All outputs are decoded from the registered state, counters and result
// flag only (Moore). Run latency from the accepting edge k to DONE is
// N_PATTERNS*(CHAIN_LEN+1) + CHAIN_LEN + 2 edges.
// -----------------------------------------------------------------------------
module bist_controller #(
  parameter int                CHAIN_LEN  = 8,
  parameter int                N_PATTERNS = 100,
  parameter int                MISR_W     = 16,
  parameter logic [MISR_W-1:0] GOLDEN_SIG = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bist_start,
  input  logic [MISR_W-1:0] misr_sig,
  output logic              test_mode,
  output logic              init,
  output logic              scan_en,
  output logic              capture,
  output logic              lfsr_en,
  output logic              misr_en,
  output logic              busy,
  output logic              bist_end,
  output logic              pass_nfail
);

  // Counters are sized to hold exactly CHAIN_LEN-1 and N_PATTERNS-1. A
  // single-bit floor keeps the degenerate length-1 configurations legal.
  localparam int BIT_W = (CHAIN_LEN  > 1) ? $clog2(CHAIN_LEN)  : 1;
  localparam int PAT_W = (N_PATTERNS > 1) ? $clog2(N_PATTERNS) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_LEN - 1);
  localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(N_PATTERNS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    FLUSH   = 3'd4,
    COMPARE = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t           state, state_next;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_next;
  logic [PAT_W-1:0] pat_cnt, pat_cnt_next;
  logic             pass_q, pass_next;

  logic bit_last;
  assign bit_last = (bit_cnt == BIT_LAST);

  // ---------------------------------------------------------------------------
  // State, counter and result registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      pat_cnt <= '0;
      pass_q  <= 1'b0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      pat_cnt <= pat_cnt_next;
      pass_q  <= pass_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, counter update and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next   = state;
    bit_cnt_next = bit_cnt;
    pat_cnt_next = pat_cnt;
    pass_next    = pass_q;
    test_mode    = 1'b0;
    init         = 1'b0;
    scan_en      = 1'b0;
    capture      = 1'b0;
    lfsr_en      = 1'b0;
    misr_en      = 1'b0;
    busy         = 1'b0;
    bist_end     = 1'b0;

    unique case (state)
      IDLE: begin
        bit_cnt_next = '0;
        pat_cnt_next = '0;
        pass_next    = 1'b0;
        if (bist_start) state_next = INIT;
      end

      INIT: begin
        init         = 1'b1;
        test_mode    = 1'b1;
        busy         = 1'b1;
        bit_cnt_next = '0;
        pat_cnt_next = '0;
        pass_next    = 1'b0;
        state_next   = SHIFT;
      end

      SHIFT: begin
        scan_en   = 1'b1;
        lfsr_en   = 1'b1;
        test_mode = 1'b1;
        busy      = 1'b1;
        // The first pattern shifts out the reset contents of the chain,
        // which carry no response worth compacting.
        misr_en   = (pat_cnt != '0);
        if (bit_last) begin
          bit_cnt_next = '0;
          state_next   = CAPTURE;
        end else begin
          bit_cnt_next = bit_cnt + BIT_W'(1);
        end
      end

      CAPTURE: begin
        capture   = 1'b1;
        test_mode = 1'b1;
        busy      = 1'b1;
        if (pat_cnt == PAT_LAST) begin
          state_next = FLUSH;
        end else begin
          pat_cnt_next = pat_cnt + PAT_W'(1);
          state_next   = SHIFT;
        end
      end

      FLUSH: begin
        // Shift the last captured response into the MISR without
        // advancing the LFSR.
        scan_en   = 1'b1;
        misr_en   = 1'b1;
        test_mode = 1'b1;
        busy      = 1'b1;
        if (bit_last) begin
          bit_cnt_next = '0;
          state_next   = COMPARE;
        end else begin
          bit_cnt_next = bit_cnt + BIT_W'(1);
        end
      end

      COMPARE: begin
        test_mode  = 1'b1;
        busy       = 1'b1;
        pass_next  = (misr_sig == GOLDEN_SIG);
        state_next = DONE;
      end

      DONE: begin
        bist_end = 1'b1;
        // A held request keeps the result visible; it never restarts a run.
        if (!bist_start) begin
          pass_next  = 1'b0;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign pass_nfail = pass_q;

endmodule

// File: tb/tb_bist_controller.sv
// -----------------------------------------------------------------------------
// tb_bist_controller
//
// Drives two controllers from one clock: a nominal configuration
// (CHAIN_LEN=8, N_PATTERNS=4) and the minimum configuration (1, 1). The
// reference model maps "edges since the run was accepted" onto the expected
// output vector with plain arithmetic. The stimulus randomizes the MISR
// signature, the point where the request is dropped and the time held in DONE.
// -----------------------------------------------------------------------------
module tb_bist_controller;

  localparam int              MISR_W = 16;
  localparam logic [15:0]     GOLD_A = 16'hA5C3;
  localparam logic [15:0]     GOLD_B = 16'h1E70;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, start_b;
  logic [MISR_W-1:0] sig_a, sig_b;

  // Output vector order:
  //   {test_mode, init, scan_en, capture, lfsr_en, misr_en, busy, bist_end, pass_nfail}
  logic tm_a, in_a, se_a, cp_a, le_a, me_a, bz_a, be_a, pn_a;
  logic tm_b, in_b, se_b, cp_b, le_b, me_b, bz_b, be_b, pn_b;
  logic [8:0] out_a, out_b;
  assign out_a = {tm_a, in_a, se_a, cp_a, le_a, me_a, bz_a, be_a, pn_a};
  assign out_b = {tm_b, in_b, se_b, cp_b, le_b, me_b, bz_b, be_b, pn_b};

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bist_controller #(
    .CHAIN_LEN(8), .N_PATTERNS(4), .MISR_W(MISR_W), .GOLDEN_SIG(GOLD_A)
  ) dut_a (
    .clock(clk), .reset(rst_n), .bist_start(start_a), .misr_sig(sig_a),
    .test_mode(tm_a), .init(in_a), .scan_en(se_a), .capture(cp_a),
    .lfsr_en(le_a), .misr_en(me_a), .busy(bz_a), .bist_end(be_a),
    .pass_nfail(pn_a)
  );

  bist_controller #(
    .CHAIN_LEN(1), .N_PATTERNS(1), .MISR_W(MISR_W), .GOLDEN_SIG(GOLD_B)
  ) dut_b (
    .clock(clk), .reset(rst_n), .bist_start(start_b), .misr_sig(sig_b),
    .test_mode(tm_b), .init(in_b), .scan_en(se_b), .capture(cp_b),
    .lfsr_en(le_b), .misr_en(me_b), .busy(bz_b), .bist_end(be_b),
    .pass_nfail(pn_b)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Expected outputs j edges after the accepting edge (j=0 is the INIT cycle).
  // The timeline is INIT, then N blocks of (C shift cycles + 1 capture),
  // then C flush cycles, one COMPARE cycle, and DONE.
  function automatic logic [8:0] model(input int c, input int n, input int j,
                                       input bit match);
    int m, p, r;
    if (j == 0)                  return 9'b1_1_0_0_0_0_1_0_0;
    if (j <= n * (c + 1)) begin
      m = j - 1;
      p = m / (c + 1);
      r = m % (c + 1);
      if (r < c) return {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, (p != 0), 1'b1, 2'b00};
      return 9'b1_0_0_1_0_0_1_0_0;
    end
    if (j <= n * (c + 1) + c)    return 9'b1_0_1_0_0_1_1_0_0;
    if (j == n * (c + 1) + c + 1) return 9'b1_0_0_0_0_0_1_0_0;
    return {7'b0, 1'b1, match};
  endfunction

  function automatic logic [15:0] bad_sig(input logic [15:0] gold);
    return gold ^ (16'h1 << $urandom_range(15, 0));
  endfunction

  task automatic drive(input bit sel, input logic start, input logic [15:0] sig);
    if (sel) begin start_b = start; sig_b = sig; end
    else     begin start_a = start; sig_a = sig; end
  endtask

  // One complete run, entered and left at a falling edge. The request is
  // dropped after the check at edge k+drop_j. With hold > 0 the request is
  // kept through DONE for that many extra cycles.
  task automatic run_cfg(input bit sel, input bit match, input int drop_j,
                         input int hold, input string name);
    int c, n, t_done, t_cmp;
    int n_scan, n_cap, n_misr, n_lfsr, n_init, first_end;
    logic [15:0] gold;
    logic        start_now;
    logic [8:0]  obs;
    c = sel ? 1 : 8;
    n = sel ? 1 : 4;
    gold = sel ? GOLD_B : GOLD_A;
    t_done = n * (c + 1) + c + 2;
    t_cmp  = t_done - 1;
    n_scan = 0; n_cap = 0; n_misr = 0; n_lfsr = 0; n_init = 0; first_end = -1;
    start_now = 1'b1;
    // Until COMPARE, present the signature opposite to the requested
    // outcome, so only the COMPARE-cycle value can decide the result.
    drive(sel, 1'b1, match ? bad_sig(gold) : gold);
    for (int j = 0; j <= t_done + hold; j++) begin
      @(posedge clk);
      @(negedge clk);
      obs = sel ? out_b : out_a;
      check($sformatf("%s_j%0d", name, j), 32'(obs), 32'(model(c, n, j, match)));
      if (j < t_done) begin
        n_init += int'(obs[7]); n_scan += int'(obs[6]); n_cap += int'(obs[5]);
        n_lfsr += int'(obs[4]); n_misr += int'(obs[3]);
      end
      if (first_end < 0 && obs[1]) first_end = j;
      if (j == drop_j) start_now = 1'b0;
      drive(sel, start_now, (j == t_cmp) ? (match ? gold : bad_sig(gold))
                                         : (match ? bad_sig(gold) : gold));
    end
    check({name, "_latency"}, 32'(first_end), 32'(t_done));
    check({name, "_n_scan"},  32'(n_scan), 32'(n * c + c));
    check({name, "_n_cap"},   32'(n_cap),  32'(n));
    check({name, "_n_misr"},  32'(n_misr), 32'(n * c));
    check({name, "_n_lfsr"},  32'(n_lfsr), 32'(n * c));
    check({name, "_n_init"},  32'(n_init), 32'(1));
    // Release the request; the next edge must leave DONE for IDLE.
    drive(sel, 1'b0, gold);
    @(posedge clk);
    @(negedge clk);
    check({name, "_idle"}, 32'(sel ? out_b : out_a), 32'(0));
  endtask

  initial begin
    int rj;
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    sig_a = '0; sig_b = '0;
    repeat (2) @(negedge clk);
    check("reset_a", 32'(out_a), 32'(0));
    check("reset_b", 32'(out_b), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_a", 32'(out_a), 32'(0));

    // Nominal pass, request dropped at a random point mid-run.
    run_cfg(1'b0, 1'b1, $urandom_range(2, 30), 0, "a_pass");
    // Failing signature, request held until DONE.
    run_cfg(1'b0, 1'b0, 1000, 0, "a_fail");
    // Request held through DONE for a while: no auto-restart.
    run_cfg(1'b0, 1'b1, 1000, $urandom_range(3, 10), "a_hold");
    // Randomized outcome and drop point.
    run_cfg(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 45), 0, "a_rand");

    // Minimum configuration.
    run_cfg(1'b1, 1'b1, 0, 0, "b_pass");
    run_cfg(1'b1, 1'b0, 1000, 2, "b_fail");

    // Asynchronous reset between edges during pattern 2 SHIFT.
    rj = $urandom_range(19, 26);
    start_a = 1'b1;
    sig_a = GOLD_A;
    for (int j = 0; j <= rj; j++) @(negedge clk);
    check("pre_abort_scan", 32'(se_a), 32'(1));
    #2 rst_n = 1'b0;
    #1 check("async_reset_a", 32'(out_a), 32'(0));
    check("async_reset_b", 32'(out_b), 32'(0));
    start_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_abort_idle", 32'(out_a), 32'(0));
    // A full-length run must follow.
    run_cfg(1'b0, 1'b1, 5, 0, "a_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bist_controller.md
BIST_CONTROLLER -- requirements
Module: bist_controller

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 8: scan-chain length in bits, legal range >= 1.
REQ-002 SHALL have parameter N_PATTERNS, default 100: number of LFSR patterns applied, legal range >= 1.
REQ-003 SHALL have parameter MISR_W, default 16: signature width.
REQ-004 SHALL have parameter GOLDEN_SIG, default 16'h0000: expected MISR signature, MISR_W bits.
REQ-005 SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port bist_start, input, 1: request to run BIST, sampled in IDLE and DONE only.
REQ-008 SHALL have port misr_sig, input, MISR_W: current MISR signature.
REQ-009 SHALL have port test_mode, output, 1: selects BIST sources over functional inputs s/dv/l_in/test_in.
REQ-010 SHALL have port init, output, 1: one-cycle seed of the LFSR and clear of the MISR.
REQ-011 SHALL have port scan_en, output, 1: scan-chain shift enable.
REQ-012 SHALL have port capture, output, 1: one-cycle functional capture into the chain.
REQ-013 SHALL have port lfsr_en, output, 1: LFSR advance enable.
REQ-014 SHALL have port misr_en, output, 1: MISR compaction enable.
REQ-015 SHALL have port busy, output, 1: run in progress (INIT through COMPARE).
REQ-016 SHALL have port bist_end, output, 1: run complete.
REQ-017 SHALL have port pass_nfail, output, 1: 1 = signature matched GOLDEN_SIG.

Function
REQ-018 SHALL implement a Moore FSM: IDLE, INIT, SHIFT, CAPTURE, FLUSH, COMPARE, DONE; all outputs decoded from registered state and counters only.
REQ-019 SHALL, in IDLE, drive all outputs 0 and move to INIT on a rising edge with bist_start=1.
REQ-020 SHALL, in INIT (1 cycle), assert init=1, test_mode=1 and busy=1, clear bit_cnt and pat_cnt, then go to SHIFT.
REQ-021 SHALL, in SHIFT, assert scan_en, lfsr_en, test_mode and busy, and assert misr_en only when pat_cnt != 0.
REQ-022 SHALL stay in SHIFT exactly CHAIN_LEN cycles, with bit_cnt counting 0..CHAIN_LEN-1 and wrapping to 0 on exit to CAPTURE.
REQ-023 SHALL, in CAPTURE (1 cycle), assert capture, test_mode and busy with scan_en=0; if pat_cnt == N_PATTERNS-1 go to FLUSH, else increment pat_cnt and return to SHIFT.
REQ-024 SHALL, in FLUSH, assert scan_en, misr_en, test_mode and busy with lfsr_en=0, for exactly CHAIN_LEN cycles, then go to COMPARE.
REQ-025 SHALL, in COMPARE (1 cycle), register pass_nfail <= (misr_sig == GOLDEN_SIG), keep busy=1, then go to DONE.
REQ-026 SHALL, in DONE, drive bist_end=1, hold pass_nfail, and drive test_mode, busy and all enables 0.
REQ-027 SHALL leave DONE for IDLE on the first edge with bist_start=0; with bist_start held 1 it SHALL remain in DONE and never auto-restart.
REQ-028 SHALL ignore bist_start from INIT through COMPARE; deassertion mid-run SHALL NOT alter sequencing.
REQ-029 SHALL give latency as follows: if bist_start is sampled at edge k in IDLE, DONE (bist_end=1) is entered at edge k + N_PATTERNS*(CHAIN_LEN+1) + CHAIN_LEN + 2.
REQ-030 SHALL size counters to hold CHAIN_LEN-1 and N_PATTERNS-1 without overflow; no counter SHALL wrap except bit_cnt per REQ-022.
REQ-031 SHALL clear pass_nfail to 0 on entry to INIT, so a stale result is never visible during a new run.

Reset
REQ-032 SHALL, on reset=0, immediately and asynchronously force IDLE, clear all counters, and drive all outputs 0, including pass_nfail and bist_end.
REQ-033 SHALL, when reset is asserted mid-run, abort the run with no partial result retained; after release, a new bist_start SHALL perform a full-length run.

Verification
REQ-034 Async reset: assert reset=0 between clock edges during SHIFT -> all outputs 0 before next edge; state IDLE.
REQ-035 Nominal pass (CHAIN_LEN=8, N_PATTERNS=4): pulse bist_start at edge k, misr_sig=GOLDEN_SIG at COMPARE -> bist_end=1 from edge k+46, pass_nfail=1; scan_en high 40 cycles, capture 4 single-cycle pulses, misr_en high 32 cycles, lfsr_en high 32 cycles, init 1 pulse.
REQ-036 Fail: same run with misr_sig=GOLDEN_SIG^1 at COMPARE -> bist_end=1 at k+46, pass_nfail=0.
REQ-037 Handshake: drop bist_start mid-SHIFT -> identical timing; hold bist_start=1 through DONE -> stays DONE; drop -> IDLE next edge, bist_end=0, pass_nfail=0.
REQ-038 Reset mid-run: reset=0 during pattern 2 SHIFT, release, restart -> full 46-cycle run; pass_nfail low until COMPARE.
REQ-039 Minimum config (CHAIN_LEN=1, N_PATTERNS=1): bist_start at edge k -> bist_end at edge k+5; misr_en high only 1 cycle (FLUSH).
